// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle main memory between the I-cache fill
// path, the D-cache fill path and D-side write-through stores.
//   Requests : i_miss/i_miss_addr, d_miss/d_miss_addr, d_wr_req/addr/data
//   Memory   : mem_addr, mem_data_in, mem_enable, mem_wr (out);
//              mem_data_out, mem_data_valid (in)
//   Caches   : fill_addr, fill_data, {i,d}_data_we, {i,d}_tag_we
//   Status   : i_busy, d_busy (stalls), d_wr_ack (store accepted)
// A fill issues WORDS back-to-back reads, steers each returned word into the
// owning cache's data array, then writes that cache's tag.
module mem_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_enable,
  output logic        mem_wr,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid,
  output logic [15:0] fill_addr,
  output logic [15:0] fill_data,
  output logic        i_data_we,
  output logic        d_data_we,
  output logic        i_tag_we,
  output logic        d_tag_we,
  output logic        i_busy,
  output logic        d_busy,
  output logic        d_wr_ack
);
  localparam int CW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, WRITE, FILL, TAG} state_t;

  state_t        state_q;
  logic          owner_q;       // 1 = D-cache owns the fill
  logic [15:0]   base_q;
  logic [CW-1:0] issue_cnt_q, recv_cnt_q;
  logic          issue_done_q;
  logic          d_starved_q;
  // vld_pipe_q[k]: a read issued by us k cycles ago. Only a valid lining up
  // with one of our own reads is accepted, so words still in flight from
  // before a reset never land in a later fill.
  logic [MEM_LAT:1] vld_pipe_q, vld_pipe_d;

  logic        gnt_df, gnt_i, gnt_w, rd_issue, rd_accept;
  logic [15:0] issue_addr, recv_addr;

  assign gnt_df = d_miss & (d_starved_q | (~i_miss & ~d_wr_req));
  assign gnt_i  = i_miss & ~(d_starved_q & d_miss);
  assign gnt_w  = d_wr_req & ~i_miss & ~(d_starved_q & d_miss);

  assign rd_issue   = (state_q == FILL) & ~issue_done_q;
  assign rd_accept  = (state_q == FILL) & mem_data_valid & vld_pipe_q[MEM_LAT];
  assign issue_addr = base_q + (16'(issue_cnt_q) << 1);
  assign recv_addr  = base_q + (16'(recv_cnt_q) << 1);

  always_comb begin
    vld_pipe_d    = '0;
    vld_pipe_d[1] = rd_issue;
    for (int k = 2; k <= MEM_LAT; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
  end

  always_comb begin
    mem_addr    = '0;
    mem_data_in = '0;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    fill_addr   = '0;
    fill_data   = '0;
    i_data_we   = 1'b0;
    d_data_we   = 1'b0;
    i_tag_we    = 1'b0;
    d_tag_we    = 1'b0;
    i_busy      = 1'b0;
    d_busy      = 1'b0;
    d_wr_ack    = 1'b0;
    case (state_q)
      IDLE: begin
        // Busy rises in the grant cycle itself so the pipeline stalls at once;
        // held low while in reset.
        i_busy = rst_n & gnt_i;
        d_busy = rst_n & (gnt_df | gnt_w);
      end
      WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = d_wr_addr;
        mem_data_in = d_wr_data;
        d_wr_ack    = 1'b1;
        d_busy      = 1'b1;
      end
      FILL: begin
        mem_enable = rd_issue;
        mem_addr   = rd_issue ? issue_addr : 16'h0;
        fill_addr  = rd_accept ? recv_addr : 16'h0;
        fill_data  = rd_accept ? mem_data_out : 16'h0;
        i_data_we  = rd_accept & ~owner_q;
        d_data_we  = rd_accept & owner_q;
        i_busy     = ~owner_q;
        d_busy     = owner_q;
      end
      TAG: begin
        fill_addr = base_q;
        i_tag_we  = ~owner_q;
        d_tag_we  = owner_q;
        i_busy    = ~owner_q;
        d_busy    = owner_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      base_q       <= '0;
      issue_cnt_q  <= '0;
      recv_cnt_q   <= '0;
      issue_done_q <= 1'b0;
      d_starved_q  <= 1'b0;
      vld_pipe_q   <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      case (state_q)
        IDLE: begin
          issue_cnt_q  <= '0;
          recv_cnt_q   <= '0;
          issue_done_q <= 1'b0;
          if (gnt_df) begin
            state_q     <= FILL;
            owner_q     <= 1'b1;
            base_q      <= d_miss_addr & 16'hFFF0;
            d_starved_q <= 1'b0;
          end else if (gnt_i) begin
            state_q     <= FILL;
            owner_q     <= 1'b0;
            base_q      <= i_miss_addr & 16'hFFF0;
            d_starved_q <= d_miss;
          end else if (gnt_w) begin
            state_q <= WRITE;
          end
        end
        WRITE: state_q <= IDLE;
        FILL: begin
          if (rd_issue) begin
            issue_cnt_q <= issue_cnt_q + CW'(1);
            if (issue_cnt_q == CW'(WORDS-1)) issue_done_q <= 1'b1;
          end
          if (rd_accept) begin
            recv_cnt_q <= recv_cnt_q + CW'(1);
            if (recv_cnt_q == CW'(WORDS-1)) state_q <= TAG;
          end
        end
        TAG:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 4-cycle-latency memory model feeds read data;
// fill words and tag writes expected at each grant are queued and popped as
// the DUT strobes them. Per-cycle control timing is checked inside each task.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic [15:0] mem_addr, mem_data_in, mem_data_out, fill_addr, fill_data;
  logic        mem_enable, mem_wr, mem_data_valid;
  logic        i_data_we, d_data_we, i_tag_we, d_tag_we, i_busy, d_busy, d_wr_ack;
  logic        spur_v = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(4), .WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_enable(mem_enable),
    .mem_wr(mem_wr), .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .i_data_we(i_data_we), .d_data_we(d_data_we),
    .i_tag_we(i_tag_we), .d_tag_we(d_tag_we),
    .i_busy(i_busy), .d_busy(d_busy), .d_wr_ack(d_wr_ack)
  );

  // memory model: not reset, so reads in flight across a DUT reset still return
  function automatic logic [15:0] memf(logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C3C;
  endfunction

  logic [3:0]  mv = '0;
  logic [15:0] ma [4];
  always @(posedge clk) begin
    mv    <= {mv[2:0], mem_enable & ~mem_wr};
    ma[0] <= mem_addr;
    ma[1] <= ma[0];
    ma[2] <= ma[1];
    ma[3] <= ma[2];
  end
  assign mem_data_valid = mv[3] | spur_v;
  assign mem_data_out   = mv[3] ? memf(ma[3]) : 16'hDEAD;

  // scoreboard of fill-word and tag strobes
  typedef struct packed {
    logic [3:0]  strb;   // {i_data_we, d_data_we, i_tag_we, d_tag_we}
    logic [15:0] addr;
    logic [15:0] data;
  } sb_t;
  sb_t sb[$];

  task automatic push_fill(input logic own, input logic [15:0] b, input int nw, input bit tag);
    for (int k = 0; k < nw; k++)
      sb.push_back('{strb: own ? 4'b0100 : 4'b1000, addr: b + 16'(2*k), data: memf(b + 16'(2*k))});
    if (tag) sb.push_back('{strb: own ? 4'b0001 : 4'b0010, addr: b, data: 16'h0});
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (i_data_we | d_data_we | i_tag_we | d_tag_we)) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected strb=%b addr=%h required=no strobe", {i_data_we, d_data_we, i_tag_we, d_tag_we}, fill_addr);
      end else begin
        sb_t e;
        e = sb.pop_front();
        if ({i_data_we, d_data_we, i_tag_we, d_tag_we} !== e.strb || fill_addr !== e.addr ||
            ((e.strb[3] | e.strb[2]) && fill_data !== e.data)) begin
          n_fail++;
          $display("FAIL sb_word strb=%b addr=%h data=%h required strb=%b addr=%h data=%h",
                   {i_data_we, d_data_we, i_tag_we, d_tag_we}, fill_addr, fill_data, e.strb, e.addr, e.data);
        end
      end
    end
  end

  logic [8:0]  ctl;
  logic [72:0] all_o;
  assign ctl   = {mem_enable, mem_wr, i_data_we, d_data_we, i_tag_we, d_tag_we, i_busy, d_busy, d_wr_ack};
  assign all_o = {mem_addr, mem_data_in, mem_enable, mem_wr, fill_addr, fill_data,
                  i_data_we, d_data_we, i_tag_we, d_tag_we, i_busy, d_busy, d_wr_ack};

  // expected control bits for a fill granted in cycle s
  function automatic logic [8:0] fexp(int c, int s, logic own);
    logic en, we, tg, bz;
    en = (c >= s+1) && (c <= s+8);
    we = (c >= s+5) && (c <= s+12);
    tg = (c == s+13);
    bz = (c >= s) && (c <= s+13);
    return {en, 1'b0, we & ~own, we & own, tg & ~own, tg & own, bz & ~own, bz & own, 1'b0};
  endfunction

  // expected control bits for a store granted in cycle s (WRITE in s+1)
  function automatic logic [8:0] wexp(int c, int s);
    if (c == s)   return 9'b000000010;
    if (c == s+1) return 9'b110000011;
    return 9'b0;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_miss = 1'b1; i_miss_addr = 16'h1234; d_miss = 1'b1; d_miss_addr = 16'h4000;
    d_wr_req = 1'b1; d_wr_addr = 16'h2000; d_wr_data = 16'h5555;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (all_o !== 73'b0) begin n_fail++; $display("FAIL reset_outputs got=%h required=0", all_o); end
    step();
    i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (all_o !== 73'b0) begin n_fail++; $display("FAIL idle_outputs got=%h required=0", all_o); end
  endtask

  task automatic test_i_fill();
    logic [8:0] e;
    for (int c = 0; c <= 14; c++) begin
      step();
      if (c == 0) begin i_miss = 1'b1; i_miss_addr = 16'h1236; push_fill(1'b0, 16'h1230, 8, 1'b1); end
      if (c == 1) i_miss = 1'b0;
      @(negedge clk);
      e = fexp(c, 0, 1'b0);
      n_checks++;
      if (ctl !== e) begin n_fail++; $display("FAIL i_fill_ctl c=%0d got=%b required=%b", c, ctl, e); end
      if (c >= 1 && c <= 8) begin
        n_checks++;
        if (mem_addr !== 16'h1230 + 16'(2*(c-1))) begin
          n_fail++; $display("FAIL i_fill_raddr c=%0d got=%h required=%h", c, mem_addr, 16'h1230 + 16'(2*(c-1)));
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL i_fill_sb left=%0d required=0", sb.size()); end
  endtask

  task automatic test_starve();
    logic [8:0]  e;
    int          st [3] = '{0, 14, 28};
    logic [15:0] bt [3] = '{16'h5550, 16'h4000, 16'h7770};
    for (int c = 0; c <= 42; c++) begin
      step();
      if (c == 0) begin
        i_miss = 1'b1; i_miss_addr = 16'h5556; d_miss = 1'b1; d_miss_addr = 16'h4008;
        push_fill(1'b0, 16'h5550, 8, 1'b1);
      end
      if (c == 1)  i_miss = 1'b0;
      if (c == 5)  begin i_miss = 1'b1; i_miss_addr = 16'h7772; end
      if (c == 14) push_fill(1'b1, 16'h4000, 8, 1'b1);
      if (c == 15) d_miss = 1'b0;
      if (c == 28) push_fill(1'b0, 16'h7770, 8, 1'b1);
      if (c == 29) i_miss = 1'b0;
      @(negedge clk);
      e = fexp(c, 0, 1'b0) | fexp(c, 14, 1'b1) | fexp(c, 28, 1'b0);
      n_checks++;
      if (ctl !== e) begin n_fail++; $display("FAIL starve_ctl c=%0d got=%b required=%b", c, ctl, e); end
      for (int f = 0; f < 3; f++)
        if (c == st[f] + 1) begin
          n_checks++;
          if (mem_addr !== bt[f]) begin n_fail++; $display("FAIL starve_raddr0 c=%0d got=%h required=%h", c, mem_addr, bt[f]); end
        end
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL starve_sb left=%0d required=0", sb.size()); end
  endtask

  task automatic test_write_fill();
    logic [8:0] e;
    for (int c = 0; c <= 16; c++) begin
      step();
      if (c == 0) begin
        d_wr_req = 1'b1; d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF;
        d_miss = 1'b1; d_miss_addr = 16'h4008;
      end
      if (c == 1) d_wr_req = 1'b0;
      if (c == 2) push_fill(1'b1, 16'h4000, 8, 1'b1);
      if (c == 3) d_miss = 1'b0;
      @(negedge clk);
      e = wexp(c, 0) | fexp(c, 2, 1'b1);
      n_checks++;
      if (ctl !== e) begin n_fail++; $display("FAIL wr_fill_ctl c=%0d got=%b required=%b", c, ctl, e); end
      if (c == 1) begin
        n_checks++;
        if (mem_addr !== 16'h2002 || mem_data_in !== 16'hBEEF) begin
          n_fail++; $display("FAIL wr_fill_store got=%h/%h required=2002/beef", mem_addr, mem_data_in);
        end
      end
      if (c >= 3 && c <= 10) begin
        n_checks++;
        if (mem_addr !== 16'h4000 + 16'(2*(c-3))) begin
          n_fail++; $display("FAIL wr_fill_raddr c=%0d got=%h required=%h", c, mem_addr, 16'h4000 + 16'(2*(c-3)));
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL wr_fill_sb left=%0d required=0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    logic [8:0] e;
    for (int c = 0; c <= 23; c++) begin
      step();
      if (c == 0) begin i_miss = 1'b1; i_miss_addr = 16'h3004; push_fill(1'b0, 16'h3000, 2, 1'b0); end
      if (c == 7) rst_n = 1'b0;
      if (c == 8) begin rst_n = 1'b1; i_miss_addr = 16'h6000; push_fill(1'b0, 16'h6000, 8, 1'b1); end
      if (c == 9) i_miss = 1'b0;
      if (c == 21) spur_v = 1'b1;
      if (c == 23) spur_v = 1'b0;
      @(negedge clk);
      if (c == 7) begin
        n_checks++;
        if (all_o !== 73'b0) begin n_fail++; $display("FAIL rst_mid_outputs got=%h required=0", all_o); end
      end else begin
        e = (c < 7) ? fexp(c, 0, 1'b0) : fexp(c, 8, 1'b0);
        n_checks++;
        if (ctl !== e) begin n_fail++; $display("FAIL rst_mid_ctl c=%0d got=%b required=%b", c, ctl, e); end
      end
      if (c == 9) begin
        n_checks++;
        if (mem_addr !== 16'h6000) begin n_fail++; $display("FAIL rst_mid_restart got=%h required=6000", mem_addr); end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL rst_mid_sb left=%0d required=0", sb.size()); end
  endtask

  task automatic test_flush();
    logic [8:0] e;
    for (int c = 0; c <= 17; c++) begin
      step();
      if (c == 0) begin i_miss = 1'b1; i_miss_addr = 16'h8884; push_fill(1'b0, 16'h8880, 8, 1'b1); end
      if (c == 3) i_miss = 1'b0;
      @(negedge clk);
      e = fexp(c, 0, 1'b0);
      n_checks++;
      if (ctl !== e) begin n_fail++; $display("FAIL flush_ctl c=%0d got=%b required=%b", c, ctl, e); end
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL flush_sb left=%0d required=0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  e;
    logic [15:0] at [3] = '{16'h2000, 16'h2010, 16'h2020};
    logic [15:0] dt [3] = '{16'h1111, 16'h2222, 16'h3333};
    for (int c = 0; c <= 7; c++) begin
      step();
      if (c == 0 || c == 2 || c == 4) begin d_wr_req = 1'b1; d_wr_addr = at[c/2]; d_wr_data = dt[c/2]; end
      if (c == 5) d_wr_req = 1'b0;
      @(negedge clk);
      e = wexp(c, 0) | wexp(c, 2) | wexp(c, 4);
      n_checks++;
      if (ctl !== e) begin n_fail++; $display("FAIL b2b_ctl c=%0d got=%b required=%b", c, ctl, e); end
      if (c == 1 || c == 3 || c == 5) begin
        n_checks++;
        if (mem_addr !== at[c/2] || mem_data_in !== dt[c/2]) begin
          n_fail++; $display("FAIL b2b_store c=%0d got=%h/%h required=%h/%h", c, mem_addr, mem_data_in, at[c/2], dt[c/2]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_i_fill();
    test_starve();
    test_write_fill();
    test_reset_mid();
    test_flush();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
